product_mem: RTL and testbench
==============================

PRODUCT_MEM -- requirements
Module: product_mem

Interface
REQ-001 SHALL have parameter LOGDEPTH, default 6, address width; depth = 2**LOGDEPTH entries.
REQ-002 SHALL have parameter WIDTH, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port EN_writeMem  input  1  write strobe from product writer.
REQ-006 SHALL have port writeMem_addr  input  LOGDEPTH  write address.
REQ-007 SHALL have port writeMem_val  input  WIDTH  write data.
REQ-008 SHALL have port EN_readMem  input  1  read strobe from block reader.
REQ-009 SHALL have port readMem_addr  input  LOGDEPTH  read address.
REQ-010 SHALL have port readMem_val  output  WIDTH  registered read data.
REQ-011 SHALL have port rd_valid  output  1  readMem_val holds data for a read issued last cycle.
REQ-012 SHALL have port mem_ready  output  1  init sweep done; accesses accepted.
REQ-013 SHALL have port clr_valid  input  1  invalidate all entries (block consumed).
REQ-014 SHALL have port fill_count  output  LOGDEPTH+1  number of entries written since last clear.
REQ-015 SHALL have port block_full  output  1  fill_count equals depth.
REQ-016 SHALL have port rd_unwritten_err  output  1  sticky: a read hit an entry not written since last clear.

Function
REQ-017 SHALL implement FSM states INIT and READY; INIT entered on reset.
REQ-018 In INIT, SHALL write zero to one entry per cycle, address 0 upward, then enter READY after writing entry depth-1 (depth cycles total).
REQ-019 In INIT, SHALL hold mem_ready low and ignore EN_writeMem, EN_readMem, clr_valid.
REQ-020 In READY, SHALL hold mem_ready high and stay in READY until reset.
REQ-021 Write: EN_writeMem high in READY SHALL store writeMem_val at writeMem_addr at that edge and set the entry's valid bit.
REQ-022 Read: EN_readMem high in READY SHALL present entry contents on readMem_val and assert rd_valid exactly one cycle later (latency 1).
REQ-023 With no read issued, rd_valid SHALL be low and readMem_val SHALL hold its last value.
REQ-024 Same-address read and write in the same cycle SHALL return the new write data (write-first bypass).
REQ-025 fill_count SHALL increment only when a write sets a previously-clear valid bit; rewriting a valid entry leaves it unchanged.
REQ-026 block_full SHALL equal (fill_count == 2**LOGDEPTH), combinational from the counter.
REQ-027 clr_valid SHALL clear all valid bits and fill_count to 0 at that edge; memory contents SHALL be kept.
REQ-028 clr_valid coincident with a write SHALL leave exactly that written entry valid and fill_count = 1.
REQ-029 A read of an entry whose valid bit is clear (and not bypassed per REQ-024) SHALL set rd_unwritten_err; cleared only by clr_valid or reset.
REQ-030 Addresses SHALL wrap naturally within LOGDEPTH bits; no out-of-range case exists.

Reset
REQ-031 On rst low, asynchronously: state INIT, init pointer 0, all valid bits 0, fill_count 0, readMem_val 0, rd_valid 0, mem_ready 0, rd_unwritten_err 0.
REQ-032 Reset asserted mid-INIT or mid-block SHALL restart the full INIT sweep on release; in-flight read SHALL NOT produce rd_valid.

Configuration
REQ-033 Macro PRODUCT_MEM_PARITY_EN defined: each entry SHALL store one extra even-parity bit computed on write; a read whose stored parity mismatches SHALL pulse output parity_err high in the rd_valid cycle.
REQ-034 Macro undefined: no parity storage, parity_err port absent, behaviour otherwise identical.

Structure
REQ-035 Shared package SHALL hold the FSM state enum (INIT, READY) and default LOGDEPTH/WIDTH constants, reused by the multiplier side.
REQ-036 Storage array and parity SHALL be one sub-module, product_mem_ram (sync write, registered read); FSM, valid bitmap, counters stay in product_mem.

Verification
REQ-037 Reset then idle -> mem_ready low for exactly 64 cycles, then high; read of addr 5 returns 0 and sets rd_unwritten_err.
REQ-038 Write 0xDEADBEEF to addr 3, read addr 3 next cycle -> rd_valid and readMem_val=0xDEADBEEF one cycle after read; fill_count=1.
REQ-039 Write addrs 0..63 with value addr*addr -> block_full high after 64th write; read back 0..63 streams matching values, rd_valid high 64 consecutive cycles.
REQ-040 Same-cycle write 0x1234 and read at addr 10 -> readMem_val=0x1234 next cycle; no error flagged.
REQ-041 Fill 10 entries, assert clr_valid with write to addr 7 -> fill_count=1, block_full low, rd_unwritten_err 0.
REQ-042 With PRODUCT_MEM_PARITY_EN, force-flip a stored bit at addr 2 then read -> parity_err pulses with rd_valid.

Source files
------------

// File: rtl/product_mem_pkg.sv
// Shared definitions for the product memory and the multiplier side that fills it.
// The FSM state type and default geometry live here so both sides agree.
package product_mem_pkg;

    localparam int DEF_LOGDEPTH = 6;
    localparam int DEF_WIDTH    = 32;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/product_mem_ram.sv
// Storage array for product_mem: synchronous write, registered read, write-first bypass.
// With PRODUCT_MEM_PARITY_EN defined each word carries an even-parity bit checked on read.
module product_mem_ram
    import product_mem_pkg::*;
#(
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [LOGDEPTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                re_i,
    input  logic [LOGDEPTH-1:0] raddr_i,
`ifdef PRODUCT_MEM_PARITY_EN
    output logic                perr_o,
`endif
    output logic [WIDTH-1:0]    rdata_o
);

    localparam int DEPTH = 1 << LOGDEPTH;
`ifdef PRODUCT_MEM_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [SW-1:0]    mem_q [DEPTH];
    logic [SW-1:0]    wword;
    logic [SW-1:0]    rword;
    logic             byp;
    logic [WIDTH-1:0] rdata_q;

`ifdef PRODUCT_MEM_PARITY_EN
    // Parity bit chosen so the XOR over the whole stored word is zero.
    assign wword = {^wdata_i, wdata_i};
`else
    assign wword = wdata_i;
`endif

    assign byp   = we_i && (waddr_i == raddr_i);
    assign rword = byp ? wword : mem_q[raddr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wword;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rword[WIDTH-1:0];
        end
    end

    assign rdata_o = rdata_q;

`ifdef PRODUCT_MEM_PARITY_EN
    logic perr_q;

    // One-cycle pulse aligned with the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= re_i && (^rword);
        end
    end

    assign perr_o = perr_q;
`endif

endmodule

// File: rtl/product_mem.sv
// Product memory: zeroing sweep after reset, then single-port-style write/read with a
// per-entry valid bitmap, fill counter and sticky unwritten-read flag. Option: PRODUCT_MEM_PARITY_EN.
module product_mem
    import product_mem_pkg::*;
#(
    parameter int LOGDEPTH = DEF_LOGDEPTH,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EN_writeMem,
    input  logic [LOGDEPTH-1:0] writeMem_addr,
    input  logic [WIDTH-1:0]    writeMem_val,
    input  logic                EN_readMem,
    input  logic [LOGDEPTH-1:0] readMem_addr,
    output logic [WIDTH-1:0]    readMem_val,
    output logic                rd_valid,
    output logic                mem_ready,
    input  logic                clr_valid,
    output logic [LOGDEPTH:0]   fill_count,
    output logic                block_full,
`ifdef PRODUCT_MEM_PARITY_EN
    output logic                parity_err,
`endif
    output logic                rd_unwritten_err
);

    localparam int DEPTH = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] FULL = (LOGDEPTH + 1)'(DEPTH);
    localparam logic [LOGDEPTH:0] ONE  = (LOGDEPTH + 1)'(1);

    mem_state_e          state_q;
    logic [LOGDEPTH-1:0] ptr_q;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [LOGDEPTH:0]   fill_q, fill_d;
    logic                err_q, err_d;
    logic                rdv_q;

    logic                ready;
    logic                wr_en, rd_en, rd_unwr;
    logic                ram_we;
    logic [LOGDEPTH-1:0] ram_waddr;
    logic [WIDTH-1:0]    ram_wdata;

    assign ready   = (state_q == READY);
    assign wr_en   = ready && EN_writeMem;
    assign rd_en   = ready && EN_readMem;
    assign rd_unwr = rd_en && !valid_q[readMem_addr]
                     && !(wr_en && (writeMem_addr == readMem_addr));

    // During the sweep the RAM write port belongs to the init pointer.
    assign ram_we    = ready ? wr_en : 1'b1;
    assign ram_waddr = ready ? writeMem_addr : ptr_q;
    assign ram_wdata = ready ? writeMem_val : '0;

    always_comb begin
        valid_d = valid_q;
        fill_d  = fill_q;
        err_d   = err_q;
        if (clr_valid) begin
            valid_d = '0;
            fill_d  = '0;
            err_d   = 1'b0;
            if (wr_en) begin
                valid_d[writeMem_addr] = 1'b1;
                fill_d                 = ONE;
            end
        end else begin
            if (wr_en && !valid_q[writeMem_addr]) begin
                valid_d[writeMem_addr] = 1'b1;
                fill_d                 = fill_q + ONE;
            end
            if (rd_unwr) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            valid_q <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            rdv_q <= rd_en;
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (&ptr_q) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    valid_q <= valid_d;
                    fill_q  <= fill_d;
                    err_q   <= err_d;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    product_mem_ram #(
        .LOGDEPTH (LOGDEPTH),
        .WIDTH    (WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_en),
        .raddr_i (readMem_addr),
`ifdef PRODUCT_MEM_PARITY_EN
        .perr_o  (parity_err),
`endif
        .rdata_o (readMem_val)
    );

    assign rd_valid         = rdv_q;
    assign mem_ready        = ready;
    assign fill_count       = fill_q;
    assign block_full       = (fill_q == FULL);
    assign rd_unwritten_err = err_q;

endmodule

// File: tb/tb_product_mem.sv
// Randomised bench for product_mem against an array-based model of the memory rules,
// plus directed literal checks for the init sweep, streaming, bypass and clear cases.
module tb_product_mem;

    localparam int LD = 6;
    localparam int W  = 32;
    localparam int D  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          EN_writeMem = 1'b0;
    logic [LD-1:0] writeMem_addr = '0;
    logic [W-1:0]  writeMem_val = '0;
    logic          EN_readMem = 1'b0;
    logic [LD-1:0] readMem_addr = '0;
    logic [W-1:0]  readMem_val;
    logic          rd_valid;
    logic          mem_ready;
    logic          clr_valid = 1'b0;
    logic [LD:0]   fill_count;
    logic          block_full;
    logic          rd_unwritten_err;
`ifdef PRODUCT_MEM_PARITY_EN
    logic          parity_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    product_mem #(.LOGDEPTH(LD), .WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .EN_writeMem      (EN_writeMem),
        .writeMem_addr    (writeMem_addr),
        .writeMem_val     (writeMem_val),
        .EN_readMem       (EN_readMem),
        .readMem_addr     (readMem_addr),
        .readMem_val      (readMem_val),
        .rd_valid         (rd_valid),
        .mem_ready        (mem_ready),
        .clr_valid        (clr_valid),
        .fill_count       (fill_count),
        .block_full       (block_full),
`ifdef PRODUCT_MEM_PARITY_EN
        .parity_err       (parity_err),
`endif
        .rd_unwritten_err (rd_unwritten_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arrays and counters updated per clock from the applied inputs.
    logic [W-1:0] m_mem [D];
    bit           m_valid [D];
    bit           m_bad [D];
    int           m_fill, m_init;
    bit           m_ready, m_rdv, m_err, m_perr;
    logic [W-1:0] m_rdata;

    task automatic m_reset();
        for (int i = 0; i < D; i++) begin
            m_mem[i] = '0; m_valid[i] = 0; m_bad[i] = 0;
        end
        m_fill = 0; m_init = 0; m_ready = 0; m_rdv = 0; m_err = 0; m_perr = 0;
        m_rdata = '0;
    endtask

    initial begin
        bit byp, bad;
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_reset();
            end else if (!m_ready) begin
                m_rdv = 0; m_perr = 0;
                m_init++;
                if (m_init == D) m_ready = 1;
            end else begin
                bad = 0;
                byp = EN_writeMem && (writeMem_addr == readMem_addr);
                m_rdv = EN_readMem;
                m_perr = 0;
                if (EN_readMem) begin
                    m_rdata = byp ? writeMem_val : m_mem[readMem_addr];
                    bad = !byp && !m_valid[readMem_addr];
                    m_perr = !byp && m_bad[readMem_addr];
                end
                if (clr_valid) begin
                    for (int i = 0; i < D; i++) m_valid[i] = 0;
                    m_fill = 0; m_err = 0;
                end else if (bad) begin
                    m_err = 1;
                end
                if (EN_writeMem) begin
                    m_mem[writeMem_addr] = writeMem_val;
                    m_bad[writeMem_addr] = 0;
                    if (!m_valid[writeMem_addr]) begin
                        m_valid[writeMem_addr] = 1;
                        m_fill++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_ready", mem_ready, m_ready);
        chk("rd_valid", rd_valid, m_rdv);
        chk("readMem_val", readMem_val, m_rdata);
        chk("fill_count", fill_count, m_fill);
        chk("block_full", block_full, m_fill == D);
        chk("rd_unwritten_err", rd_unwritten_err, m_err);
`ifdef PRODUCT_MEM_PARITY_EN
        chk("parity_err", parity_err, m_perr);
`endif
    end

    task automatic cyc(input bit we, input int wa, input logic [W-1:0] wv,
                       input bit re, input int ra, input bit clr);
        EN_writeMem = we; writeMem_addr = LD'(wa); writeMem_val = wv;
        EN_readMem = re; readMem_addr = LD'(ra); clr_valid = clr;
        @(posedge clk); #1;
        EN_writeMem = 0; EN_readMem = 0; clr_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        EN_writeMem = 0; EN_readMem = 0; clr_valid = 0;
        rst = 0;
        @(negedge clk);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_rdata", readMem_val, 0);
        chk("rst_err", rd_unwritten_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic init_count();
        int cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_ready) break;
            cnt++;
        end
        chk("init_low_cycles", cnt, 64);
    endtask

    initial begin
        int streak;
        // Reset, partial sweep, reset again mid-INIT: the sweep restarts from zero.
        do_reset();
        repeat (20) @(posedge clk);
        do_reset();
        init_count();

        // Read of untouched entry: zero data, sticky error.
        cyc(0, 0, 0, 1, 5, 0);
        @(negedge clk);
        chk("r5_rdv", rd_valid, 1);
        chk("r5_val", readMem_val, 0);
        chk("r5_err", rd_unwritten_err, 1);

        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 3, 32'hDEADBEEF, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0);
        @(negedge clk);
        chk("r3_rdv", rd_valid, 1);
        chk("r3_val", readMem_val, 32'hDEADBEEF);
        chk("r3_fill", fill_count, 1);

        // Full block of squares, then a back-to-back read stream.
        cyc(0, 0, 0, 0, 0, 1);
        for (int a = 0; a < D; a++) cyc(1, a, W'(a * a), 0, 0, 0);
        @(negedge clk);
        chk("full_flag", block_full, 1);
        chk("full_fill", fill_count, 64);
        streak = 0;
        for (int a = 0; a < D; a++) begin
            EN_readMem = 1; readMem_addr = LD'(a);
            @(posedge clk); #1;
            @(negedge clk);
            if (rd_valid) streak++;
            chk("stream_val", readMem_val, W'(a * a));
        end
        EN_readMem = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_streak", streak, 64);
        chk("stream_end_rdv", rd_valid, 0);

        // Same-cycle write/read at a cleared entry: bypass, no error.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 10, 32'h1234, 1, 10, 0);
        @(negedge clk);
        chk("byp_val", readMem_val, 32'h1234);
        chk("byp_err", rd_unwritten_err, 0);

        cyc(0, 0, 0, 0, 0, 1);
        for (int a = 20; a < 30; a++) cyc(1, a, W'(a), 0, 0, 0);
        @(negedge clk);
        chk("fill10", fill_count, 10);
        cyc(1, 7, 32'h77, 0, 0, 1);
        @(negedge clk);
        chk("clrw_fill", fill_count, 1);
        chk("clrw_full", block_full, 0);
        chk("clrw_err", rd_unwritten_err, 0);

        // Reset while a read is in flight: no rd_valid, full sweep again.
        EN_readMem = 1; readMem_addr = 6'd7;
        #3 rst = 0;
        EN_readMem = 0;
        @(negedge clk);
        chk("inflight_rdv", rd_valid, 0);
        chk("inflight_fill", fill_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        init_count();

        // Random traffic, biased toward a small address window for hits and bypasses.
        for (int n = 0; n < 1500; n++) begin
            int wa, ra;
            wa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 15));
            cyc($urandom_range(0, 1) == 1, wa, W'($urandom), $urandom_range(0, 1) == 1, ra,
                $urandom_range(0, 60) == 0);
        end

`ifdef PRODUCT_MEM_PARITY_EN
        cyc(1, 2, 32'h55, 0, 0, 0);
        dut.u_ram.mem_q[2][0] = ~dut.u_ram.mem_q[2][0];
        m_bad[2] = 1;
        m_mem[2] = m_mem[2] ^ 32'h1;
        cyc(0, 0, 0, 1, 2, 0);
        @(negedge clk);
        chk("par_pulse", parity_err, 1);
        chk("par_rdv", rd_valid, 1);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
